exception_sequencer: RTL and testbench

Multicycle sequencer that takes over memory addressing when an exception is raised. It drives the memory-address select code consumed by the IorD address mux, fetches the handler-address byte from the exception vector location, saves EPC, and loads the handler address into PC. It sits between the main control unit and the IorD mux. In normal operation it passes the main control's select code straight through.

---
 rtl/exception_sequencer_pkg.sv | 33 +++
 rtl/exception_sequencer_if.sv | 37 +++
 rtl/exception_sequencer.sv | 122 ++++++++++++
 tb/tb_exception_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/exception_sequencer_pkg.sv
// Shared types and constants for the exception sequencer: FSM state
// encoding, IorD select codes and the exception-priority encoder.
package exception_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CAPTURE  = 3'd1,
      ST_MEM_WAIT = 3'd2,
      ST_LOAD_PC  = 3'd3,
      ST_DONE     = 3'd4
   } exc_state_t;

   localparam logic [2:0] SEL_PC   = 3'b000;
   localparam logic [2:0] SEL_DIV0 = 3'b001;
   localparam logic [2:0] SEL_OVF  = 3'b010;
   localparam logic [2:0] SEL_NOOP = 3'b011;

   // Highest-priority pending exception; SEL_PC means none is pending.
   function automatic logic [2:0] exc_priority(input logic opcode_invalid,
                                               input logic overflow,
                                               input logic div_zero);
      logic [2:0] code;
      code = SEL_PC;
      if (opcode_invalid)
         code = SEL_NOOP;
      else if (overflow)
         code = SEL_OVF;
      else if (div_zero)
         code = SEL_DIV0;
      return code;
   endfunction

endpackage

// File: rtl/exception_sequencer_if.sv
// Signal bundle between main control / datapath and the exception
// sequencer. master = control/datapath side, slave = the sequencer.
interface exception_sequencer_if;

   logic        exc_check;
   logic        overflow;
   logic        div_zero;
   logic        opcode_invalid;
   logic [2:0]  iord_main;
   logic [31:0] PC_out;
   logic [31:0] mem_data_out;
   logic        cause_clr;

   logic [2:0]  IorDControl;
   logic        EPC_write;
   logic [31:0] epc_value;
   logic        PC_write_exc;
   logic [31:0] pc_exc_value;
   logic        exc_busy;
   logic        exc_done;
   logic [31:0] exc_cause;

   modport master (
      output exc_check, overflow, div_zero, opcode_invalid, iord_main,
             PC_out, mem_data_out, cause_clr,
      input  IorDControl, EPC_write, epc_value, PC_write_exc, pc_exc_value,
             exc_busy, exc_done, exc_cause
   );

   modport slave (
      input  exc_check, overflow, div_zero, opcode_invalid, iord_main,
             PC_out, mem_data_out, cause_clr,
      output IorDControl, EPC_write, epc_value, PC_write_exc, pc_exc_value,
             exc_busy, exc_done, exc_cause
   );

endinterface

// File: rtl/exception_sequencer.sv
// Exception sequencer: takes over the IorD address select when an
// exception is qualified, saves EPC, waits MEM_LATENCY cycles for the
// handler-vector byte and loads it into PC.
// Optional feature macro: EXC_CAUSE_REG_EN (latched cause register).
module exception_sequencer
   import exception_sequencer_pkg::*;
#(
   parameter int MEM_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   exception_sequencer_if.slave  bus
);

   // Final wait count; unused when MEM_LATENCY is 0 because CAPTURE
   // then jumps straight to LOAD_PC.
   localparam logic [3:0] LAST_CNT = (MEM_LATENCY == 0) ? 4'd0 : 4'(MEM_LATENCY - 1);

   exc_state_t  r_state;
   logic [3:0]  r_cnt;
   logic [2:0]  r_iord;
   logic [31:0] r_epc;
   logic        r_epc_write;
   logic        r_pc_write;
   logic        r_busy;
   logic        r_done;

   logic [2:0]  w_code;
   logic        w_take;

   assign w_code = exc_priority(bus.opcode_invalid, bus.overflow, bus.div_zero);
   assign w_take = (r_state == ST_IDLE) && bus.exc_check && (w_code != SEL_PC);

   // Sequencer FSM with registered strobes, select code and EPC value
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_iord      <= SEL_PC;
         r_epc       <= 32'd0;
         r_epc_write <= 1'b0;
         r_pc_write  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_epc_write <= 1'b0;
         r_pc_write  <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_take) begin
                  r_state     <= ST_CAPTURE;
                  r_iord      <= w_code;
                  r_epc       <= bus.PC_out - 32'd4;
                  r_epc_write <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            ST_CAPTURE: begin
               r_cnt <= 4'd0;
               if (MEM_LATENCY == 0) begin
                  r_state    <= ST_LOAD_PC;
                  r_pc_write <= 1'b1;
               end else begin
                  r_state <= ST_MEM_WAIT;
               end
            end
            ST_MEM_WAIT: begin
               if (r_cnt == LAST_CNT) begin
                  r_state    <= ST_LOAD_PC;
                  r_cnt      <= 4'd0;
                  r_pc_write <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            ST_LOAD_PC: begin
               r_state <= ST_DONE;
               r_iord  <= SEL_PC;
               r_done  <= 1'b1;
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef EXC_CAUSE_REG_EN
   logic [31:0] r_cause;

   // Cause register: a new capture takes precedence over a clear
   always_ff @(posedge clk) begin
      if (reset)
         r_cause <= 32'd0;
      else if (w_take)
         r_cause <= {29'd0, w_code};
      else if (bus.cause_clr)
         r_cause <= 32'd0;
   end

   assign bus.exc_cause = r_cause;
`else
   assign bus.exc_cause = 32'd0;
`endif

   // Main control owns the address select while idle
   assign bus.IorDControl  = (r_state == ST_IDLE) ? bus.iord_main : r_iord;
   assign bus.EPC_write    = r_epc_write;
   assign bus.epc_value    = r_epc;
   assign bus.PC_write_exc = r_pc_write;
   // Only the low byte of the vector location is the handler address
   assign bus.pc_exc_value = (r_state == ST_LOAD_PC) ? {24'd0, bus.mem_data_out[7:0]} : 32'd0;
   assign bus.exc_busy     = r_busy;
   assign bus.exc_done     = r_done;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed testbench for exception_sequencer: one instance with
// MEM_LATENCY=2 and one with MEM_LATENCY=0. Expected cause value
// follows the EXC_CAUSE_REG_EN build option.
module tb_exception_sequencer;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

`ifdef EXC_CAUSE_REG_EN
   localparam logic [31:0] EXP_CAUSE_NOOP = 32'd3;
`else
   localparam logic [31:0] EXP_CAUSE_NOOP = 32'd0;
`endif

   exception_sequencer_if if_a ();
   exception_sequencer_if if_b ();

   exception_sequencer #(.MEM_LATENCY(2)) u_lat2 (
      .clk   (clk),
      .reset (reset),
      .bus   (if_a.slave)
   );

   exception_sequencer #(.MEM_LATENCY(0)) u_lat0 (
      .clk   (clk),
      .reset (reset),
      .bus   (if_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // advance to the next falling edge (one rising edge in between)
   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      int busy_cnt;
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      if_a.exc_check = 0; if_a.overflow = 0; if_a.div_zero = 0; if_a.opcode_invalid = 0;
      if_a.iord_main = 3'b000; if_a.PC_out = 32'h0; if_a.mem_data_out = 32'h0; if_a.cause_clr = 0;
      if_b.exc_check = 0; if_b.overflow = 0; if_b.div_zero = 0; if_b.opcode_invalid = 0;
      if_b.iord_main = 3'b000; if_b.PC_out = 32'h0; if_b.mem_data_out = 32'h0; if_b.cause_clr = 0;

      // ---- reset state
      cyc(); cyc();
      check("rst_iord",   32'(if_a.IorDControl), 32'h0);
      check("rst_epcw",   32'(if_a.EPC_write), 32'h0);
      check("rst_pcw",    32'(if_a.PC_write_exc), 32'h0);
      check("rst_busy",   32'(if_a.exc_busy), 32'h0);
      check("rst_done",   32'(if_a.exc_done), 32'h0);
      check("rst_epc",    if_a.epc_value, 32'h0);
      check("rst_pcexc",  if_a.pc_exc_value, 32'h0);
      check("rst_cause",  if_a.exc_cause, 32'h0);
      reset = 1'b0;

      // ---- idle pass-through, flags ignored without exc_check
      if_a.iord_main = 3'b101;
      if_a.overflow  = 1'b1;
      cyc();
      check("pass_iord",  32'(if_a.IorDControl), 32'h5);
      check("nochk_busy", 32'(if_a.exc_busy), 32'h0);
      check("nochk_epcw", 32'(if_a.EPC_write), 32'h0);

      // ---- overflow, MEM_LATENCY=2, PC 0x40, handler byte 0x7C
      if_a.PC_out       = 32'h0000_0040;
      if_a.mem_data_out = 32'hABCD_EF7C;
      if_a.exc_check    = 1'b1;
      cyc();                                   // CAPTURE
      if_a.exc_check = 1'b0; if_a.overflow = 1'b0;
      check("ovf_cap_epcw", 32'(if_a.EPC_write), 32'h1);
      check("ovf_cap_epc",  if_a.epc_value, 32'h0000_003C);
      check("ovf_cap_iord", 32'(if_a.IorDControl), 32'h2);
      check("ovf_cap_busy", 32'(if_a.exc_busy), 32'h1);
      cyc();                                   // MEM_WAIT 0
      check("ovf_mw0_iord", 32'(if_a.IorDControl), 32'h2);
      check("ovf_mw0_epcw", 32'(if_a.EPC_write), 32'h0);
      check("ovf_mw0_pcw",  32'(if_a.PC_write_exc), 32'h0);
      cyc();                                   // MEM_WAIT 1
      check("ovf_mw1_iord", 32'(if_a.IorDControl), 32'h2);
      check("ovf_mw1_pcw",  32'(if_a.PC_write_exc), 32'h0);
      cyc();                                   // LOAD_PC
      check("ovf_ld_pcw",   32'(if_a.PC_write_exc), 32'h1);
      check("ovf_ld_pcval", if_a.pc_exc_value, 32'h0000_007C);
      check("ovf_ld_iord",  32'(if_a.IorDControl), 32'h2);
      check("ovf_ld_done",  32'(if_a.exc_done), 32'h0);
      cyc();                                   // DONE
      check("ovf_dn_done",  32'(if_a.exc_done), 32'h1);
      check("ovf_dn_iord",  32'(if_a.IorDControl), 32'h0);
      check("ovf_dn_busy",  32'(if_a.exc_busy), 32'h1);
      check("ovf_dn_pcw",   32'(if_a.PC_write_exc), 32'h0);
      cyc();                                   // IDLE
      check("ovf_idle_busy", 32'(if_a.exc_busy), 32'h0);
      check("ovf_idle_done", 32'(if_a.exc_done), 32'h0);
      check("ovf_idle_iord", 32'(if_a.IorDControl), 32'h5);

      // ---- all three flags: opcode_invalid wins
      if_a.exc_check = 1'b1; if_a.overflow = 1'b1; if_a.div_zero = 1'b1; if_a.opcode_invalid = 1'b1;
      if_a.PC_out = 32'h0000_1000;
      cyc();                                   // CAPTURE
      if_a.exc_check = 1'b0; if_a.overflow = 1'b0; if_a.div_zero = 1'b0; if_a.opcode_invalid = 1'b0;
      check("all_iord",  32'(if_a.IorDControl), 32'h3);
      check("all_cause", if_a.exc_cause, EXP_CAUSE_NOOP);
      check("all_epc",   if_a.epc_value, 32'h0000_0FFC);
      cyc();                                   // MEM_WAIT 0: pulse overflow
      if_a.exc_check = 1'b1; if_a.overflow = 1'b1;
      cyc();                                   // MEM_WAIT 1
      if_a.exc_check = 1'b0; if_a.overflow = 1'b0;
      check("busyflag_iord",  32'(if_a.IorDControl), 32'h3);
      check("busyflag_cause", if_a.exc_cause, EXP_CAUSE_NOOP);
      check("busyflag_epcw",  32'(if_a.EPC_write), 32'h0);
      cyc();                                   // LOAD_PC
      check("busyflag_ld",    32'(if_a.PC_write_exc), 32'h1);
      cyc();                                   // DONE
      check("busyflag_done",  32'(if_a.exc_done), 32'h1);
      cyc();                                   // IDLE, no restart
      check("busyflag_idle",  32'(if_a.exc_busy), 32'h0);
      cyc();
      check("busyflag_norst", 32'(if_a.EPC_write), 32'h0);
      check("cause_hold",     if_a.exc_cause, EXP_CAUSE_NOOP);
      if_a.cause_clr = 1'b1;
      cyc();
      if_a.cause_clr = 1'b0;
      check("cause_clr",      if_a.exc_cause, 32'h0);

      // ---- reset asserted in MEM_WAIT
      if_a.PC_out = 32'h0000_0100;
      if_a.exc_check = 1'b1; if_a.overflow = 1'b1;
      cyc();                                   // CAPTURE
      if_a.exc_check = 1'b0; if_a.overflow = 1'b0;
      check("rmid_epcw", 32'(if_a.EPC_write), 32'h1);
      cyc();                                   // MEM_WAIT 0
      reset = 1'b1;
      cyc();                                   // reset taken
      reset = 1'b0;
      check("rmid_busy", 32'(if_a.exc_busy), 32'h0);
      check("rmid_iord", 32'(if_a.IorDControl), 32'h5);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check($sformatf("rmid_nopcw%0d", i), 32'(if_a.PC_write_exc), 32'h0);
         check($sformatf("rmid_nobusy%0d", i), 32'(if_a.exc_busy), 32'h0);
      end

      // ---- PC wrap: PC_out=0 with overflow
      if_a.PC_out = 32'h0;
      if_a.exc_check = 1'b1; if_a.overflow = 1'b1;
      cyc();
      if_a.exc_check = 1'b0; if_a.overflow = 1'b0;
      check("wrap_epcw", 32'(if_a.EPC_write), 32'h1);
      check("wrap_epc",  if_a.epc_value, 32'hFFFF_FFFC);
      repeat (5) cyc();
      check("wrap_idle", 32'(if_a.exc_busy), 32'h0);

      // ---- MEM_LATENCY=0 with div_zero
      if_b.PC_out       = 32'h0000_0200;
      if_b.mem_data_out = 32'hFFFF_FF11;
      if_b.iord_main    = 3'b110;
      if_b.exc_check    = 1'b1; if_b.div_zero = 1'b1;
      busy_cnt = 0;
      cyc();                                   // CAPTURE
      if_b.exc_check = 1'b0; if_b.div_zero = 1'b0;
      if (if_b.exc_busy) busy_cnt++;
      check("l0_cap_iord", 32'(if_b.IorDControl), 32'h1);
      check("l0_cap_epcw", 32'(if_b.EPC_write), 32'h1);
      check("l0_cap_epc",  if_b.epc_value, 32'h0000_01FC);
      cyc();                                   // LOAD_PC
      if (if_b.exc_busy) busy_cnt++;
      check("l0_ld_pcw",   32'(if_b.PC_write_exc), 32'h1);
      check("l0_ld_pcval", if_b.pc_exc_value, 32'h0000_0011);
      check("l0_ld_iord",  32'(if_b.IorDControl), 32'h1);
      cyc();                                   // DONE
      if (if_b.exc_busy) busy_cnt++;
      check("l0_dn_done",  32'(if_b.exc_done), 32'h1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (if_b.exc_busy) busy_cnt++;
      end
      check("l0_busy_cycles", 32'(busy_cnt), 32'd3);
      check("l0_idle_iord",   32'(if_b.IorDControl), 32'h6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
